// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes,
// default latencies and the controller state type.
package e_mdu_pkg;

    // MDU operation codes carried from the decoder into the E stage.
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    // Default busy latencies in cycles.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Latency counter width; must hold the larger of the two latencies.
    localparam int CNT_W = 4;

    // Controller state; busy is simply (state == ST_RUN).
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. Owns HI/LO, computes the 64-bit result in
// the issue cycle and holds it as pending until the modelled latency
// expires, at which point HI/LO are written.
//
// Issue handshake: start is a combinational "accepted" pulse, high exactly
// when mdu_op is a mult/div op and busy is low; the op is taken on that
// clock edge. busy is registered and is high for exactly N cycles after
// the accepting edge; while busy is high every incoming op is dropped.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    mdu_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [63:0]        pend;
    logic               pend_wr;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    mdu_op_e            op;
    logic               is_md_op;
    logic [63:0]        result;
    logic               result_wr;
    logic [CNT_W-1:0]   op_cycles;

    logic signed [63:0] a_s64;
    logic signed [63:0] b_s64;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        b_safe;
    logic signed [32:0] dvd_s;
    logic signed [32:0] dvs_s;
    logic signed [32:0] quo_s;
    logic signed [32:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic               div_unused;

    assign op       = mdu_op_e'(mdu_op);
    assign is_md_op = (op == MDU_MULT) || (op == MDU_MULTU) ||
                      (op == MDU_DIV)  || (op == MDU_DIVU);
    assign busy     = (state == ST_RUN);
    assign start    = is_md_op && !busy;
    assign HI       = hi_q;
    assign LO       = lo_q;

    // Full-width arithmetic for the current operands. Signed divide runs at
    // 33 bits so 0x80000000 / -1 yields +2^31, whose low word is 0x80000000.
    // A zero divisor is replaced by 1 only to keep the dividers defined;
    // that result is never committed.
    always_comb begin
        a_s64  = {{32{A[31]}}, A};
        b_s64  = {{32{B[31]}}, B};
        prod_s = a_s64 * b_s64;
        prod_u = {32'd0, A} * {32'd0, B};
        b_safe = (B == 32'd0) ? 32'd1 : B;
        dvd_s  = {A[31], A};
        dvs_s  = {b_safe[31], b_safe};
        quo_s  = dvd_s / dvs_s;
        rem_s  = dvd_s % dvs_s;
        quo_u  = A / b_safe;
        rem_u  = A % b_safe;
        div_unused = quo_s[32] ^ rem_s[32];
    end

    // Select the pending result, its write enable and latency for the op.
    always_comb begin
        result    = 64'd0;
        result_wr = 1'b0;
        op_cycles = CNT_W'(MULT_CYCLES);
        case (op)
            MDU_MULT: begin
                result    = prod_s;
                result_wr = 1'b1;
            end
            MDU_MULTU: begin
                result    = prod_u;
                result_wr = 1'b1;
            end
            MDU_DIV: begin
                result    = {rem_s[31:0], quo_s[31:0]};
                result_wr = (B != 32'd0);
                op_cycles = CNT_W'(DIV_CYCLES);
            end
            MDU_DIVU: begin
                result    = {rem_u, quo_u};
                result_wr = (B != 32'd0);
                op_cycles = CNT_W'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    // Read port: old HI/LO are returned even while a result is pending.
    always_comb begin
        md_out = 32'd0;
        if (op == MDU_MFHI)
            md_out = hi_q;
        else if (op == MDU_MFLO)
            md_out = lo_q;
    end

    // Controller: issue/latency tracking and HI/LO updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pend    <= result;
                        pend_wr <= result_wr;
                        cnt     <= op_cycles;
                        state   <= ST_RUN;
                    end else if (op == MDU_MTHI) begin
                        hi_q <= A;
                    end else if (op == MDU_MTLO) begin
                        lo_q <= A;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        if (pend_wr) begin
                            hi_q <= pend[63:32];
                            lo_q <= pend[31:0];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit for the execute stage of the 5-stage MIPS pipeline.
- Consumes the E-stage operands (rs/rt values after forwarding) and an MDU op decoded from the E-stage instruction.
- Owns the HI/LO registers and models multi-cycle mult/div latency with a busy flag.
- The hazard unit uses that flag to stall MDU instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- mdu_op  input  4  MDU operation of the E-stage instruction (encoding in Decomposition).
- A  input  32  rs operand (forwarded RD1_E).
- B  input  32  rt operand (forwarded RD2_E).
- start  output  1  combinational; 1 when mdu_op is MULT/MULTU/DIV/DIVU and busy=0.
- busy  output  1  registered; 1 while a mult/div is in progress.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- md_out  output  32  combinational; HI if mdu_op=MFHI, LO if mdu_op=MFLO, else 0.

Behaviour:
- Reset: busy=0, HI=0, LO=0, counter=0, pending result=0. Reset at any edge, including mid-operation, discards the pending result; HI/LO read 0 the next cycle.
- States: IDLE (busy=0) and RUN (busy=1). Counter width is 4 bits and must hold max(MULT_CYCLES, DIV_CYCLES).
- IDLE -> RUN on an edge where start=1:
  - Compute the 64-bit result from A/B of that cycle and store it as pending.
  - Load counter with the op's cycle count.
  - busy=1 from the next cycle.
- RUN: counter decrements each edge. busy stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). On the edge where counter reaches 0: busy goes to 0, and HI/LO take the pending value at that same edge.
- Timing: start in cycle t gives busy=1 in cycles t+1..t+N. New HI/LO are visible in cycle t+N+1.
- Arithmetic:
  - mult: signed 64-bit product; HI=prod[63:32], LO=prod[31:0].
  - multu: unsigned 64-bit product, same split.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient (LO) and remainder (HI).
- Divide by zero (B=0, div or divu): busy still runs DIV_CYCLES; HI/LO left unchanged at completion.
- MTHI/MTLO when busy=0: HI (resp. LO) <= A at the edge, visible next cycle.
- Any MDU op while busy=1 is ignored: no start, no MTHI/MTLO write, no counter change. The hazard unit guarantees this case does not occur; RTL must still ignore it.
- MFHI/MFLO while busy=1: md_out returns the current (old) HI/LO. Stall is the hazard unit's job.
- mdu_op=NONE or any unused code: no state change, md_out=0.
- A flushed E stage presents mdu_op=NONE, since the cleared instr_E decodes to NONE.

Decomposition:
- Shared package holds:
  - MDU op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - Default MULT_CYCLES and DIV_CYCLES values.
- The controller decodes instr_E into mdu_op using the package constants.
- No sub-module: the block is a single counter/FSM plus combinational arithmetic.

Test Plan:
1. Reset, then mflo -> md_out=0, busy=0. Assert reset while busy=1 -> next cycle busy=0, HI=LO=0.
2. mult A=0xFFFFFFFE (-2), B=3 at cycle t -> busy=1 for t+1..t+5. At t+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
3. div A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
4. HI=0x11, LO=0x22, then div B=0 -> busy runs 10 cycles; afterwards HI=0x11, LO=0x22 unchanged.
5. mthi A=0xDEADBEEF, then mtlo A=0x12345678 -> next cycles mfhi/mflo give md_out 0xDEADBEEF / 0x12345678.
6. mult in flight: inject mtlo and multu during busy -> both ignored, result equals the first mult. Also check div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
